spi_slave_fifo: RTL and testbench
=================================

SPI_SLAVE_FIFO -- requirements
Module: spi_slave_fifo

Interface
REQ-001 SHALL have parameter WORDSIZE, default 8, meaning SPI word length in bits, legal range 1..32.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning entries per RX and per TX FIFO, power of two, 2..64.
REQ-003 SHALL have parameter MSB_FIRST, default 1, meaning 1 = MSB shifted first, 0 = LSB first.
REQ-004 SHALL have parameter IDLE_WORD, default 0, meaning word transmitted when the TX FIFO is empty.
REQ-005 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port mode  input  2  {CPOL,CPHA}; latched only while ss is inactive.
REQ-008 SHALL have ports sck, mosi, ss  input  1 each  asynchronous SPI pins; ss active-low.
REQ-009 SHALL have ports miso, miso_outen  output  1 each  SPI data out and its output enable.
REQ-010 SHALL have ports tx_data input WORDSIZE, tx_valid input 1, tx_ready output 1  TX FIFO push handshake.
REQ-011 SHALL have ports rx_data output WORDSIZE, rx_valid output 1, rx_ready input 1  RX FIFO pop handshake.
REQ-012 SHALL have ports rx_overflow, tx_underrun  output  1 each  single-cycle error pulses.
REQ-013 SHALL have port busy  output  1  high while ss (synchronised) is active.

Function
REQ-014 SHALL synchronise sck, mosi, ss through two flip-flops each; sck edges detected from synchronised history.
REQ-015 SHALL latch mode on every cycle with synchronised ss high; mode changes during a transfer SHALL be ignored.
REQ-016 SHALL use sample edge = falling sck when CPOL^CPHA, else rising; setup edge is the opposite.
REQ-017 SHALL implement states IDLE (ss high), LOAD (word start), SHIFT (bits in progress); IDLE->LOAD on ss low; LOAD->SHIFT next cycle; SHIFT->LOAD after WORDSIZE sample edges; any state->IDLE on ss high.
REQ-018 In LOAD, SHALL pop one TX FIFO entry into the TX shift register if non-empty, else load IDLE_WORD and pulse tx_underrun for one cycle.
REQ-019 With CPHA=0, SHALL drive the first bit on miso in the cycle after LOAD; remaining bits on setup edges.
REQ-020 With CPHA=1, SHALL drive each bit, including the first, on setup edges; miso = 0 until the first setup edge.
REQ-021 SHALL shift mosi into the RX shift register on each sample edge, order per MSB_FIRST.
REQ-022 On the WORDSIZE-th sample edge, SHALL push the completed word into the RX FIFO in the following cycle; rx_valid visible one cycle after the push.
REQ-023 If the RX FIFO is full at push time and no pop occurs in the same cycle, SHALL drop the new word and pulse rx_overflow one cycle.
REQ-024 Simultaneous push and pop on a full RX FIFO SHALL succeed both, no overflow.
REQ-025 tx_ready SHALL be high iff the TX FIFO is not full; a push happens on tx_valid&tx_ready; simultaneous push and LOAD-pop on full SHALL both succeed.
REQ-026 rx_valid SHALL be high iff RX FIFO is non-empty; rx_data SHALL show the head entry; pop on rx_valid&rx_ready.
REQ-027 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrapping modulo 2*FIFO_DEPTH; full/empty from MSB compare.
REQ-028 ss high mid-word SHALL discard the partial RX word, NOT push it, and NOT return the popped TX word.
REQ-029 miso_outen SHALL be 1 exactly while synchronised ss is low; miso SHALL be 0 while miso_outen is 0.

Reset
REQ-030 On rst=1 at a clk edge: state IDLE, both FIFOs empty, shift registers and bit counter 0, latched mode 00.
REQ-031 During and after reset: miso=0, miso_outen=0, rx_valid=0, tx_ready=1, rx_overflow=0, tx_underrun=0, busy=0.
REQ-032 rst SHALL override all other inputs, including an active ss mid-word.

Verification
REQ-033 Mode 00, MSB first, push 0xA5 then ss low, 8 sck cycles with mosi=0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid=1.
REQ-034 Modes 01, 10, 11 each, exchange 0x81/0x7E -> correct bits on correct edges; mode toggled mid-transfer has no effect.
REQ-035 Empty TX FIFO, one word transferred -> miso sends IDLE_WORD, tx_underrun pulses once.
REQ-036 FIFO_DEPTH=4, rx_ready=0, five words sent -> first four retained in order, fifth dropped, rx_overflow pulses once.
REQ-037 ss raised after 3 bits, then full word 0x55 -> only 0x55 in RX FIFO; TX advances to the next entry.
REQ-038 rst asserted at bit 5 -> all outputs at reset values next cycle; next transfer correct.

Source files
------------

// File: rtl/spi_slave_fifo.sv
// SPI slave with RX/TX FIFOs. SPI pins are synchronised into the clk domain.
// A three-state FSM frames words. The TX FIFO feeds the MISO shifter and
// the RX FIFO collects completed MOSI words.
module spi_slave_fifo #(
    parameter int          WORDSIZE   = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic [31:0] IDLE_WORD  = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic                sck,
    input  logic                mosi,
    input  logic                ss,
    output logic                miso,
    output logic                miso_outen,
    input  logic [WORDSIZE-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [WORDSIZE-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                rx_overflow,
    output logic                tx_underrun,
    output logic                busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(WORDSIZE + 1);
    localparam logic [WORDSIZE-1:0] IDLE_W   = IDLE_WORD[WORDSIZE-1:0];
    localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]       CNT_LAST = CW'(WORDSIZE - 1);
    localparam logic [PW-1:0]       PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // Shift one bit into a word, toward the end that leaves the wire first.
    function automatic logic [WORDSIZE-1:0] shift_in(input logic [WORDSIZE-1:0] w, input logic b);
        logic [WORDSIZE-1:0] r;
        r = w;
        if (MSB_FIRST) begin
            for (int i = WORDSIZE - 1; i > 0; i--) r[i] = w[i-1];
            r[0] = b;
        end else begin
            for (int i = 0; i < WORDSIZE - 1; i++) r[i] = w[i+1];
            r[WORDSIZE-1] = b;
        end
        return r;
    endfunction

    // Bit of a word that goes on the wire next.
    function automatic logic first_bit(input logic [WORDSIZE-1:0] w);
        return MSB_FIRST ? w[WORDSIZE-1] : w[0];
    endfunction

    logic sck_m, sck_q, sck_d, mosi_m, mosi_q, ss_m, ss_q;
    logic [1:0] mode_r;
    state_t state, state_n;
    logic [CW-1:0] bit_cnt;
    logic [WORDSIZE-1:0] rx_sh, tx_sh, rx_word_r;
    logic miso_r, rx_push_r, rx_overflow_r, tx_underrun_r;

    logic [WORDSIZE-1:0] tx_mem [FIFO_DEPTH];
    logic [WORDSIZE-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;

    logic cpol, cpha, sck_rise, sck_fall, sample_edge, setup_edge, active;
    logic in_load, in_shift, do_sample, do_setup, word_done;
    logic tx_empty, tx_full, tx_push, tx_pop, rx_empty, rx_full, rx_pop, rx_wr, overflow_s;
    logic [WORDSIZE-1:0] load_word;

    assign cpol        = mode_r[1];
    assign cpha        = mode_r[0];
    assign sck_rise    = sck_q & ~sck_d;
    assign sck_fall    = ~sck_q & sck_d;
    assign sample_edge = (cpol ^ cpha) ? sck_fall : sck_rise;
    assign setup_edge  = (cpol ^ cpha) ? sck_rise : sck_fall;
    assign active      = ~ss_q;
    assign in_load     = (state == ST_LOAD) && active;
    assign in_shift    = (state == ST_SHIFT) && active;
    assign do_sample   = in_shift && sample_edge;
    assign word_done   = do_sample && (bit_cnt == CNT_LAST);
    // With CPHA=0 the setup edge that trails the last sample of a word belongs
    // to no bit, so setup edges only shift once this word has sampled something.
    assign do_setup    = in_shift && setup_edge && (cpha || (bit_cnt != {CW{1'b0}}));

    assign tx_empty  = (tx_wp == tx_rp);
    assign tx_full   = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign tx_push   = tx_valid & ~tx_full;
    assign tx_pop    = in_load & ~tx_empty;
    assign load_word = tx_empty ? IDLE_W : tx_mem[tx_rp[AW-1:0]];

    assign rx_empty   = (rx_wp == rx_rp);
    assign rx_full    = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign rx_pop     = ~rx_empty & rx_ready;
    assign rx_wr      = rx_push_r & (~rx_full | rx_pop);
    assign overflow_s = rx_push_r & rx_full & ~rx_pop;

    assign busy        = ~ss_q;
    assign miso_outen  = ~ss_q;
    assign miso        = miso_r & ~ss_q;
    assign tx_ready    = ~tx_full;
    assign rx_valid    = ~rx_empty;
    assign rx_data     = rx_mem[rx_rp[AW-1:0]];
    assign rx_overflow = rx_overflow_r;
    assign tx_underrun = tx_underrun_r;

    // Two-flop synchronisers for the SPI pins plus one history flop for sck edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_m  <= 1'b0; sck_q  <= 1'b0; sck_d <= 1'b0;
            mosi_m <= 1'b0; mosi_q <= 1'b0;
            ss_m   <= 1'b1; ss_q   <= 1'b1;
        end else begin
            sck_m  <= sck;  sck_q  <= sck_m; sck_d <= sck_q;
            mosi_m <= mosi; mosi_q <= mosi_m;
            ss_m   <= ss;   ss_q   <= ss_m;
        end
    end

    // Mode only follows the input while the slave is deselected.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r <= 2'b00;
        end else if (ss_q) begin
            mode_r <= mode;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next state; deselect forces IDLE from anywhere.
    always_comb begin
        state_n = state;
        if (!active) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  state_n = ST_LOAD;
                ST_LOAD:  state_n = ST_SHIFT;
                ST_SHIFT: begin
                    if (word_done) state_n = ST_LOAD;
                    else           state_n = ST_SHIFT;
                end
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    // Shift datapath: word load, MOSI capture, MISO drive and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt       <= {CW{1'b0}};
            rx_sh         <= {WORDSIZE{1'b0}};
            tx_sh         <= {WORDSIZE{1'b0}};
            rx_word_r     <= {WORDSIZE{1'b0}};
            miso_r        <= 1'b0;
            rx_push_r     <= 1'b0;
            rx_overflow_r <= 1'b0;
            tx_underrun_r <= 1'b0;
        end else begin
            rx_push_r     <= word_done;
            rx_overflow_r <= overflow_s;
            tx_underrun_r <= in_load & tx_empty;
            if (!active) begin
                bit_cnt <= {CW{1'b0}};
                rx_sh   <= {WORDSIZE{1'b0}};
                miso_r  <= 1'b0;
            end else if (in_load) begin
                bit_cnt <= {CW{1'b0}};
                if (cpha) begin
                    miso_r <= 1'b0;
                    tx_sh  <= load_word;
                end else begin
                    miso_r <= first_bit(load_word);
                    tx_sh  <= shift_in(load_word, 1'b0);
                end
            end else begin
                if (do_sample) begin
                    rx_sh <= shift_in(rx_sh, mosi_q);
                    if (word_done) begin
                        bit_cnt   <= {CW{1'b0}};
                        rx_word_r <= shift_in(rx_sh, mosi_q);
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
                if (do_setup) begin
                    miso_r <= first_bit(tx_sh);
                    tx_sh  <= shift_in(tx_sh, 1'b0);
                end
            end
        end
    end

    // TX FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp <= {PW{1'b0}};
            tx_rp <= {PW{1'b0}};
        end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
        end
    end

    // TX FIFO storage.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= tx_data;
    end

    // RX FIFO pointers; a push on full is allowed when the head pops in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp <= {PW{1'b0}};
            rx_rp <= {PW{1'b0}};
        end else begin
            if (rx_wr)  rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop) rx_rp <= rx_rp + PTR_ONE;
        end
    end

    // RX FIFO storage.
    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem[rx_wp[AW-1:0]] <= rx_word_r;
    end

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Directed testbench for spi_slave_fifo: acts as the SPI master and FIFO host.
module tb_spi_slave_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       sck = 1'b0, mosi = 1'b0, ss = 1'b1;
    logic       miso, miso_outen;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready = 1'b0;
    logic       rx_overflow, tx_underrun, busy;

    logic       cpol = 1'b0, cpha = 1'b0;
    int         n_checks = 0, n_pass = 0;
    int         ur_cnt = 0, ov_cnt = 0;

    spi_slave_fifo #(
        .WORDSIZE(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b1), .IDLE_WORD(32'h0000_005A)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .sck(sck), .mosi(mosi), .ss(ss),
        .miso(miso), .miso_outen(miso_outen),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overflow(rx_overflow), .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    // Count error pulses (cycles high) for later comparison.
    always @(posedge clk) begin
        if (tx_underrun) ur_cnt <= ur_cnt + 1;
        if (rx_overflow) ov_cnt <= ov_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_data = d; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx(input string tag, input logic [7:0] exp);
        check_eq({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        check_eq({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp});
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    task automatic ss_low();
        ss = 1'b0;
        tick(8);
    endtask

    task automatic ss_high();
        ss = 1'b1;
        tick(8);
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode = m; cpol = m[1]; cpha = m[0]; sck = m[1];
        tick(6);
    endtask

    // Master side of nbits bit times, MSB first; returns the MISO bits seen.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = tx[7-i];
                tick(8);
                rx[7-i] = miso;
                sck = ~cpol;
                tick(8);
                sck = cpol;
            end else begin
                sck = ~cpol;
                mosi = tx[7-i];
                tick(8);
                rx[7-i] = miso;
                sck = cpol;
                tick(8);
            end
        end
    endtask

    initial begin
        logic [7:0] got;
        logic [1:0] m;
        int base;

        tick(3);
        rst = 1'b0;
        tick(1);
        check_eq("rst_miso", {31'd0, miso}, 32'd0);
        check_eq("rst_outen", {31'd0, miso_outen}, 32'd0);
        check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check_eq("rst_rx_overflow", {31'd0, rx_overflow}, 32'd0);
        check_eq("rst_tx_underrun", {31'd0, tx_underrun}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);

        // Mode 00 basic exchange A5 out / 3C in.
        set_mode(2'b00);
        push_tx(8'hA5);
        ss_low();
        check_eq("m00_first_bit", {31'd0, miso}, 32'd1);
        check_eq("m00_busy", {31'd0, busy}, 32'd1);
        check_eq("m00_outen", {31'd0, miso_outen}, 32'd1);
        xfer(8'h3C, 8, got);
        check_eq("m00_miso_word", {24'd0, got}, 32'h0000_00A5);
        ss_high();
        pop_rx("m00_rx", 8'h3C);

        // Modes 01, 10, 11 with the mode input flipped mid-word.
        for (int k = 1; k < 4; k++) begin
            m = k[1:0];
            set_mode(m);
            push_tx(8'h81);
            ss_low();
            check_eq("mode_first_bit", {31'd0, miso}, m[0] ? 32'd0 : 32'd1);
            mode = ~m;
            xfer(8'h7E, 8, got);
            check_eq("mode_miso_word", {24'd0, got}, 32'h0000_0081);
            ss_high();
            pop_rx("mode_rx", 8'h7E);
        end
        set_mode(2'b00);

        // Empty TX FIFO sends the idle word and flags one underrun at word start.
        base = ur_cnt;
        ss_low();
        check_eq("ur_pulses", ur_cnt - base, 32'd1);
        xfer(8'h11, 8, got);
        check_eq("ur_miso_word", {24'd0, got}, 32'h0000_005A);
        ss_high();
        pop_rx("ur_rx", 8'h11);

        // Aborted word after 3 bits is discarded; TX moves on to the next entry.
        push_tx(8'hB1);
        push_tx(8'h22);
        ss_low();
        xfer(8'hE0, 3, got);
        check_eq("abort_partial_miso", {24'd0, got}, 32'h0000_00A0);
        ss_high();
        ss_low();
        xfer(8'h55, 8, got);
        check_eq("abort_next_miso", {24'd0, got}, 32'h0000_0022);
        ss_high();
        pop_rx("abort_rx", 8'h55);
        check_eq("abort_rx_empty", {31'd0, rx_valid}, 32'd0);

        // Five words into a four-deep RX FIFO with no pops.
        base = ov_cnt;
        ss_low();
        for (int w = 1; w <= 5; w++) xfer(w[7:0], 8, got);
        ss_high();
        check_eq("ovf_pulses", ov_cnt - base, 32'd1);
        for (int w = 1; w <= 4; w++) pop_rx("ovf_rx", w[7:0]);
        check_eq("ovf_rx_empty", {31'd0, rx_valid}, 32'd0);

        // Reset in the middle of a word, then a clean transfer.
        push_tx(8'h44);
        push_tx(8'h55);
        push_tx(8'h66);
        push_tx(8'h77);
        check_eq("tx_full_ready", {31'd0, tx_ready}, 32'd0);
        ss_low();
        xfer(8'hE1, 8, got);
        check_eq("pre_rst_miso", {24'd0, got}, 32'h0000_0044);
        xfer(8'hFF, 5, got);
        check_eq("pre_rst_rx_valid", {31'd0, rx_valid}, 32'd1);
        rst = 1'b1;
        tick(1);
        check_eq("mid_rst_miso", {31'd0, miso}, 32'd0);
        check_eq("mid_rst_outen", {31'd0, miso_outen}, 32'd0);
        check_eq("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check_eq("mid_rst_rx_overflow", {31'd0, rx_overflow}, 32'd0);
        check_eq("mid_rst_tx_underrun", {31'd0, tx_underrun}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        ss = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(4);
        push_tx(8'hC3);
        ss_low();
        check_eq("post_rst_first_bit", {31'd0, miso}, 32'd1);
        xfer(8'h96, 8, got);
        check_eq("post_rst_miso", {24'd0, got}, 32'h0000_00C3);
        ss_high();
        pop_rx("post_rst_rx", 8'h96);
        check_eq("post_rst_rx_empty", {31'd0, rx_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
